dff_bank_arbiter: RTL and testbench
===================================

# dff_bank_arbiter

Round-robin write arbiter and sequencer for a shared W-bit register bank built from the team's positive-edge D flip-flop cells. Up to N requesters compete for write access. The block grants one requester at a time, performs exactly one write per grant, and reports completion. It sits between requester logic and the shared storage, and is the only writer of that storage.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 4, register width in bits

Ports (one clock; reset is asynchronous and active-high):
- c  in  1  clock; all state updates on the rising edge
- r  in  1  reset, asynchronous, active-high
- req  in  N  request lines, one per requester; held high until granted and served
- wdata  in  N*W  write data; requester i drives bits [i*W +: W]
- gnt  out  N  one-hot grant; all zero when idle
- q  out  W  current contents of the shared register
- wdone  out  1  one-cycle pulse in the cycle after q takes a new value
- busy  out  1  high whenever the state is not IDLE

## Operation
- Reset values, forced immediately while r=1 regardless of c:
  - state = IDLE
  - q = 0, gnt = 0, wdone = 0, busy = 0
  - round-robin pointer ptr = 0
- IDLE
  - If any req bit is high, select the first requester at or above ptr, wrapping modulo N. Latch its index as sel.
  - Set gnt = onehot(sel) and go to WRITE.
  - If no req bit is high, remain in IDLE.
- WRITE (exactly 1 cycle)
  - If req[sel] is still high: q <= wdata[sel], wdone pulses, go to HOLD.
  - If req[sel] has dropped: abort. q is unchanged, wdone is not pulsed, gnt clears, ptr <= (sel+1) mod N, go to IDLE.
- HOLD
  - gnt stays asserted while req[sel] is high. No further writes occur.
  - When req[sel] is sampled low: gnt clears, ptr <= (sel+1) mod N, go to IDLE.
- Requests from other requesters while the block is busy wait; they are not lost.
- Changes on the other req bits never alter sel mid-transaction.
- ptr wraps from N-1 back to 0.
- With a single persistent requester, that requester is served repeatedly, once per transaction.

## Timing
- Cycle k: req[i] is sampled high in IDLE. After edge k, gnt[i] = 1 and busy = 1.
- Edge k+1: q updates. After edge k+1, wdone = 1 for one cycle.
- Minimum transaction length, counted from the grant to the return to IDLE:
  - the grant cycle (WRITE), then
  - at least one HOLD cycle, then
  - one mandatory IDLE cycle before the next grant.
- Back-to-back grants are therefore at least 3 cycles apart.
- wdata[sel] must be stable during the WRITE cycle only.
- Asserting r mid-transaction:
  - gnt and wdone drop at once.
  - q clears to 0, including during the WRITE cycle (no partial write).
  - Release of r takes effect at the next rising edge.
- Simultaneous requests are resolved only by ptr. There is no fixed priority.

## Structure
- Shared package holds:
  - state encoding constants IDLE=0, WRITE=1, HOLD=2 (2-bit)
  - the default N and W values
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req[N], ptr.
  - Outputs: sel index and valid.
- Storage is W instances of the existing DFlipFlop cell, with a clear path for r. It is written only when the state is WRITE.

## Test plan
- Reset: hold r=1 for 2 cycles with req=4'b1111 -> gnt=0, q=0, busy=0, wdone=0 throughout.
- Single write: req=4'b0100, wdata[2]=4'hA -> gnt=4'b0100 next cycle, q=4'hA one cycle later, wdone high for exactly 1 cycle; drop req -> gnt=0, then IDLE.
- Fairness: req=4'b1111 held, each requester dropping its req one cycle after its wdone -> grant order 0,1,2,3,0; every grant is separated by at least 3 cycles.
- Wrap: ptr=3 after serving requester 2, then req=4'b1001 -> requester 3 is granted first, then requester 0.
- Abort: requester 1 granted, req[1] drops during WRITE with wdata[1]=4'h5 and q=4'h3 -> q stays 4'h3, no wdone, ptr=2.
- Reset mid-write: r pulsed during the WRITE cycle while q=4'hF -> q=0 and gnt=0 immediately; after release, the next grant follows round-robin from ptr=0.

Source files
------------

// File: rtl/dff_bank_arbiter_pkg.sv
// Shared constants for the round-robin register-bank write arbiter.
package dff_bank_arbiter_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // Next requester index after idx, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/DFlipFlop.sv
// Positive-edge D flip-flop cell with asynchronous active-high clear.
module DFlipFlop (
  input  logic c,
  input  logic r,
  input  logic d,
  output logic q
);
  always_ff @(posedge c or posedge r) begin
    if (r) q <= 1'b0;
    else   q <= d;
  end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          vld
);
  int idx;

  always_comb begin
    vld = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!vld && req[idx]) begin
        vld = 1'b1;
        sel = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared DFF register: one write per grant, wdone pulses after q updates.
// Grant one edge after request, write on the next; grant held until the winner drops its request.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           c,
  input  logic           r,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           wdone,
  output logic           busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]    state, state_nxt;
  logic [IW-1:0] sel, sel_nxt, ptr, ptr_nxt, pick;
  logic          pick_vld, wdone_nxt, req_sel, we;
  logic [W-1:0]  wsel, d;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .sel(pick),
    .vld(pick_vld)
  );

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      wdone <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      wdone <= wdone_nxt;
    end
  end

  // Selected requester's request line and data, muxed by the latched sel.
  always_comb begin
    req_sel = 1'b0;
    wsel    = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        req_sel = req[i];
        wsel    = wdata[i*W +: W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    wdone_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = WRITE;
          sel_nxt   = pick;
        end
      end
      WRITE: begin
        if (req_sel) begin
          state_nxt = HOLD;
          wdone_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          ptr_nxt   = IW'(wrap_inc(int'(sel), N));
        end
      end
      HOLD: begin
        if (!req_sel) begin
          state_nxt = IDLE;
          ptr_nxt   = IW'(wrap_inc(int'(sel), N));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    gnt  = '0;
    if (busy) gnt[sel] = 1'b1;
  end

  // An aborted WRITE (request dropped) leaves the register untouched.
  assign we = (state == WRITE) && req_sel;
  assign d  = we ? wsel : q;

  for (genvar b = 0; b < W; b++) begin : g_bit
    DFlipFlop u_ff (
      .c(c),
      .r(r),
      .d(d[b]),
      .q(q[b])
    );
  end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: vector table plus fairness and reset-mid-write sequences.
module tb_dff_bank_arbiter;
  logic        c, r;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  q;
  logic        wdone, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  dff_bank_arbiter #(.N(4), .W(4)) dut (
    .c(c), .r(r), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .wdone(wdone), .busy(busy)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  always @(posedge c) cyc <= cyc + 1;

  typedef struct packed {
    logic        r;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        wdone;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #2;
  endtask

  task automatic add(input logic rr, input logic [3:0] rq, input logic [15:0] wd,
                     input logic [3:0] eg, input logic [3:0] eq, input logic ew, input logic eb);
    vec_t v;
    v.r = rr; v.req = rq; v.wdata = wd;
    v.gnt = eg; v.q = eq; v.wdone = ew; v.busy = eb;
    vq.push_back(v);
  endtask

  initial begin
    int ord[5];
    int last_g;
    int t;
    int e;

    r = 1'b1; req = 4'b1111; wdata = '0;
    ord = '{0, 1, 2, 3, 0};

    //   r  req      wdata     gnt      q     wd  busy
    add(1, 4'b1111, 16'h0000, 4'b0000, 4'h0, 0, 0); // reset held with all requests
    add(1, 4'b1111, 16'h0000, 4'b0000, 4'h0, 0, 0);
    add(0, 4'b0100, 16'h0A00, 4'b0100, 4'h0, 0, 1); // single write: grant 2
    add(0, 4'b0100, 16'h0A00, 4'b0100, 4'hA, 1, 1); // write A, wdone
    add(0, 4'b0100, 16'h0000, 4'b0100, 4'hA, 0, 1); // hold, wdone one cycle only
    add(0, 4'b0000, 16'h0000, 4'b0000, 4'hA, 0, 0); // release -> ptr=3
    add(0, 4'b1001, 16'h7002, 4'b1000, 4'hA, 0, 1); // wrap: 3 before 0
    add(0, 4'b1001, 16'h7002, 4'b1000, 4'h7, 1, 1);
    add(0, 4'b0001, 16'h7002, 4'b0000, 4'h7, 0, 0); // release -> ptr=0
    add(0, 4'b0001, 16'h0003, 4'b0001, 4'h7, 0, 1); // then 0
    add(0, 4'b0001, 16'h0003, 4'b0001, 4'h3, 1, 1);
    add(0, 4'b0000, 16'h0003, 4'b0000, 4'h3, 0, 0); // ptr=1
    add(0, 4'b0010, 16'h0050, 4'b0010, 4'h3, 0, 1); // abort: grant 1
    add(0, 4'b0000, 16'h0050, 4'b0000, 4'h3, 0, 0); // drop in WRITE -> no write, ptr=2
    add(0, 4'b0111, 16'h0C00, 4'b0100, 4'h3, 0, 1); // ptr=2 picks 2
    add(0, 4'b0111, 16'h0C00, 4'b0100, 4'hC, 1, 1);
    add(0, 4'b0011, 16'h0000, 4'b0000, 4'hC, 0, 0); // ptr=3
    add(0, 4'b0011, 16'h0009, 4'b0001, 4'hC, 0, 1); // 3 idle -> wraps to 0
    add(0, 4'b0011, 16'h0009, 4'b0001, 4'h9, 1, 1);
    add(0, 4'b0010, 16'h0060, 4'b0000, 4'h9, 0, 0); // ptr=1
    add(0, 4'b0010, 16'h0060, 4'b0010, 4'h9, 0, 1);
    add(0, 4'b0010, 16'h0060, 4'b0010, 4'h6, 1, 1);
    add(0, 4'b0010, 16'h0000, 4'b0010, 4'h6, 0, 1);
    add(0, 4'b0000, 16'h0000, 4'b0000, 4'h6, 0, 0);

    #1;
    chk("reset_async_gnt", 32'(gnt), 32'h0);
    chk("reset_async_q",   32'(q),   32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      r = vq[i].r; req = vq[i].req; wdata = vq[i].wdata;
      tick();
      chk($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(vq[i].gnt));
      chk($sformatf("vec%0d_q", i),     32'(q),     32'(vq[i].q));
      chk($sformatf("vec%0d_wdone", i), 32'(wdone), 32'(vq[i].wdone));
      chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(vq[i].busy));
    end

    // Fairness from ptr=0: all requesting, each drops one cycle after its wdone.
    r = 1'b1; req = 4'b0000; tick();
    r = 1'b0; req = 4'b1111; wdata = 16'hDCBA;
    last_g = -100;
    for (int g = 0; g < 5; g++) begin
      e = ord[g];
      t = 0;
      while (gnt == 4'b0000 && t < 20) begin tick(); t++; end
      chk($sformatf("fair%0d_gnt_timeout", g), 32'(t < 20), 32'h1);
      chk($sformatf("fair%0d_gnt", g), 32'(gnt), 32'(4'b0001 << e));
      if (g > 0) chk($sformatf("fair%0d_spacing_ge3", g), 32'(cyc - last_g >= 3), 32'h1);
      last_g = cyc;
      t = 0;
      while (!wdone && t < 20) begin tick(); t++; end
      chk($sformatf("fair%0d_wdone_timeout", g), 32'(t < 20), 32'h1);
      chk($sformatf("fair%0d_q", g), 32'(q), 32'((16'hDCBA >> (4 * e)) & 16'hF));
      tick();
      req[e] = 1'b0;
      t = 0;
      while (gnt != 4'b0000 && t < 20) begin tick(); t++; end
      chk($sformatf("fair%0d_release_timeout", g), 32'(t < 20), 32'h1);
      req[e] = 1'b1;
    end

    // Reset mid-write: load F via requester 2 (ptr -> 3), then reset during 3's WRITE.
    req = 4'b0000; tick(); tick();
    req = 4'b0100; wdata = 16'h0F00; tick(); tick();
    chk("rmw_q_loaded", 32'(q), 32'hF);
    req = 4'b0000; tick();
    req = 4'b1001; wdata = 16'h1002; tick();
    chk("rmw_gnt3_write", 32'(gnt), 32'(4'b1000));
    r = 1'b1; #1;
    chk("rmw_async_q",     32'(q),     32'h0);
    chk("rmw_async_gnt",   32'(gnt),   32'h0);
    chk("rmw_async_busy",  32'(busy),  32'h0);
    chk("rmw_async_wdone", 32'(wdone), 32'h0);
    tick();
    chk("rmw_held_q", 32'(q), 32'h0);
    r = 1'b0;
    tick();
    chk("rmw_regrant_ptr0", 32'(gnt), 32'(4'b0001));
    chk("rmw_regrant_q",    32'(q),   32'h0);
    tick();
    chk("rmw_regrant_write", 32'(q), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
